// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes, HI/LO unit op encodings and FSM states.
package mips_pkg;

    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_MADDU = 6'd1;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_MADDU = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/mips_mul_step.sv
// One shift-add multiply slice: adds mcand * mbits, shifted into place, to the accumulator.
module mips_mul_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHW            = $clog2(2*WIDTH)
) (
    input  logic [2*WIDTH-1:0]        acc,
    input  logic [WIDTH-1:0]          mcand,
    input  logic [BITS_PER_CYCLE-1:0] mbits,
    input  logic [SHW-1:0]            shamt,
    output logic [2*WIDTH-1:0]        sum
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mbits[i]) pp = pp + ({{WIDTH{1'b0}}, mcand} << i);
        end
        sum = acc + (pp << shamt);
    end

endmodule

// File: rtl/mips_hilo_muldiv.sv
// Multi-cycle unsigned MULTU/MADDU unit with private HI/LO pair and pipeline stall request.
//   state    | meaning
//   S_IDLE   | waiting for start; HI/LO stable and readable
//   S_RUN    | retiring BITS_PER_CYCLE multiplier bits per cycle
//   S_COMMIT | product (or accumulated sum) written to HI/LO at end of cycle
module mips_hilo_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N   = WIDTH / BITS_PER_CYCLE;
    localparam int CW  = $clog2(N + 1);
    localparam int SHW = $clog2(2*WIDTH);

    state_t             state;
    op_t                op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_sum;
    logic [2*WIDTH-1:0] commit_val;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     shamt;

    assign shamt = SHW'(32'(cnt) * BITS_PER_CYCLE);

    mips_mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHW            (SHW)
    ) u_step (
        .acc   (acc),
        .mcand (mcand),
        .mbits (mplier[BITS_PER_CYCLE-1:0]),
        .shamt (shamt),
        .sum   (step_sum)
    );

    // Carry out of the MADDU sum is intentionally dropped (mod 2^(2*WIDTH)).
    always_comb begin
        commit_val = acc;
        if (op_q == OP_MADDU) commit_val = {hi, lo} + acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_q   <= OP_MULTU;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= src_a;
                        mplier <= src_b;
                        op_q   <= op_t'(op);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= step_sum;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    {hi, lo} <= commit_val;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_COMMIT);
    // Reset low forces stall off even before the reset edge clears busy.
    assign stall   = rst & busy & (start | rd_req);
    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// Self-checking bench: directed vector table, hand-written hazard/reset sequences, random ops vs model.
module tb_mips_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, op, rd_req, rd_sel;
    logic [31:0] src_a, src_b, rd_data, hi, lo;
    logic        busy, stall, done;

    logic        start4;
    logic [31:0] rd_data4, hi4, lo4;
    logic        busy4, stall4, done4;

    int checks   = 0;
    int failures = 0;
    logic [63:0] model = 64'd0;

    always #5 clk = ~clk;

    mips_hilo_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy),
        .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    mips_hilo_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(1'b0), .src_a(32'd3), .src_b(32'd5),
        .rd_req(1'b0), .rd_sel(1'b0), .rd_data(rd_data4), .busy(busy4),
        .stall(stall4), .done(done4), .hi(hi4), .lo(lo4)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the unit idle; returns at posedge+1 on the first idle cycle.
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b, input string name);
        int bc;
        int dc;
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        model = o ? model + 64'(a) * 64'(b) : 64'(a) * 64'(b);
        bc = 0; dc = 0;
        while (busy && bc < 200) begin
            if (done) dc++;
            bc++;
            tick();
        end
        chk({name, "_busy_cycles"}, 64'(bc), 64'd33);
        chk({name, "_done_pulses"}, 64'(dc), 64'd1);
        chk({name, "_hilo"}, {hi, lo}, model);
    endtask

    initial begin
        int bc;
        int dc;
        logic stall_ok;

        vecs[0] = '{1'b0, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 32'd1,         32'd1,         32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'd0,         32'd12345,     32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000};

        rst = 1'b0; start = 1'b1; op = 1'b0; src_a = 32'd9; src_b = 32'd9;
        rd_req = 1'b1; rd_sel = 1'b0; start4 = 1'b0;
        tick(); tick();
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        start = 1'b0; rd_req = 1'b0;
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_table", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            if (i == 0) begin
                rd_req = 1'b1; rd_sel = 1'b0;
                #1;
                chk("mflo_after_vec0", 64'(rd_data), 64'd15);
                chk("mflo_idle_stall", 64'(stall), 64'd0);
                rd_req = 1'b0;
            end
        end

        // MFHI two cycles after start: stalls until the first idle cycle.
        start = 1'b1; op = 1'b0; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        model = 64'h1234_5678 * 64'h9ABC_DEF0;
        tick();
        rd_req = 1'b1; rd_sel = 1'b1;
        stall_ok = 1'b1; bc = 0;
        #1;
        while (busy && bc < 200) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            bc++;
            tick();
        end
        chk("mfhi_stall_while_busy", 64'(stall_ok), 64'd1);
        chk("mfhi_stall_cycles", 64'(bc), 64'd32);
        chk("mfhi_idle_stall", 64'(stall), 64'd0);
        chk("mfhi_rd_data", 64'(rd_data), model[63:32]);
        rd_req = 1'b0;

        // start + MFLO together in IDLE: older read sees pre-operation LO.
        do_op(1'b0, 32'd7, 32'd1, "lo7");
        start = 1'b1; op = 1'b0; src_a = 32'd2; src_b = 32'd3;
        rd_req = 1'b1; rd_sel = 1'b0;
        #1;
        chk("idle_rdstart_stall", 64'(stall), 64'd0);
        chk("idle_rdstart_data", 64'(rd_data), 64'd7);
        tick();
        start = 1'b0; rd_req = 1'b0;
        bc = 0;
        while (busy && bc < 200) begin bc++; tick(); end
        chk("idle_rdstart_result", {hi, lo}, 64'd6);
        model = 64'd6;

        // Start while busy is not accepted by itself: stall asserted, op unchanged.
        start = 1'b1; op = 1'b0; src_a = 32'd10; src_b = 32'd10;
        tick();
        src_a = 32'd50; src_b = 32'd50; op = 1'b1;
        #1;
        chk("start_busy_stall", 64'(stall), 64'd1);
        start = 1'b0;
        bc = 0;
        while (busy && bc < 200) begin bc++; tick(); end
        chk("start_busy_result", {hi, lo}, 64'd100);
        model = 64'd100;

        // Reset 10 cycles into a MULTU aborts it with no done pulse.
        start = 1'b1; op = 1'b0; src_a = 32'd11; src_b = 32'd13;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b0; rd_req = 1'b1;
        #1;
        chk("abort_stall_rst_low", 64'(stall), 64'd0);
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        rst = 1'b1; rd_req = 1'b0;
        model = 64'd0;
        dc = 0;
        repeat (40) begin
            if (done || busy) dc++;
            tick();
        end
        chk("abort_no_done", 64'(dc), 64'd0);

        // BITS_PER_CYCLE = 4: 3*5 in 9 busy cycles.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        bc = 0; dc = 0;
        while (busy4 && bc < 100) begin
            if (done4) dc++;
            bc++;
            tick();
        end
        chk("bpc4_busy_cycles", 64'(bc), 64'd9);
        chk("bpc4_done_pulses", 64'(dc), 64'd1);
        chk("bpc4_hilo", {hi4, lo4}, 64'd15);

        for (int i = 0; i < 30; i++) begin
            do_op(1'($urandom_range(0, 1)), $urandom, $urandom, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_hilo_muldiv.md
Name: mips_hilo_muldiv

Overview:
- Multi-cycle unsigned multiply / multiply-accumulate unit with its own HI/LO register pair.
- Sits beside the EX stage of mips_pipelined and executes MULTU and MADDU.
- Serves MFHI and MFLO reads.
- Drives a stall request back to the hazard logic while an operation is in flight, so that dependent instructions and new multiplies wait.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; the product is 2*WIDTH bits.
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration. Legal values are 1, 2 and 4, and must divide WIDTH. N = WIDTH/BITS_PER_CYCLE.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-low (clk, rst).
- start  in  1  EX holds a valid MULTU or MADDU this cycle.
- op  in  1  0 = MULTU, 1 = MADDU; sampled with start.
- src_a  in  WIDTH  multiplicand (rs value).
- src_b  in  WIDTH  multiplier (rt value).
- rd_req  in  1  EX holds MFHI or MFLO.
- rd_sel  in  1  0 = LO, 1 = HI.
- rd_data  out  WIDTH  selected HI/LO register value; combinational from the registers.
- busy  out  1  operation in flight.
- stall  out  1  pipeline must hold EX and earlier stages.
- done  out  1  one-cycle pulse in the cycle in which HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst = 0 at a clock edge), which also aborts any operation in flight:
  - state goes to IDLE;
  - hi = lo = 0;
  - iteration counter = 0;
  - partial product = 0;
  - busy = 0, done = 0;
  - stall = 0 while rst is low.
- States IDLE, RUN, COMMIT. busy = (state != IDLE).
- IDLE:
  - If start = 1 at edge E, latch src_a, src_b and op, clear the 2*WIDTH partial product and counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each edge adds (src_a * low BITS_PER_CYCLE bits of the multiplier) << (counter*BITS_PER_CYCLE) to the partial product, then shifts the multiplier right by BITS_PER_CYCLE and increments the counter.
  - After the N-th iteration (edge E+N), go to COMMIT.
- COMMIT:
  - done = 1 during this cycle.
  - At edge E+N+1:
    - MULTU writes {hi,lo} = product.
    - MADDU writes {hi,lo} = {hi,lo} + product, modulo 2^(2*WIDTH); the carry out is discarded.
  - Then go to IDLE.
- Latency: busy is high for exactly N+1 cycles. New HI/LO are visible from edge E+N+1. For defaults, 33 cycles.
- Arithmetic: all operands are unsigned and zero-extended to 2*WIDTH; there is no overflow detection.
- stall = busy & (start | rd_req). In IDLE, stall is always 0.
- start while busy: ignored and not queued. The pipeline holds the instruction via stall, and it is accepted on the first IDLE cycle.
- rd_req during RUN or COMMIT: stall = 1. rd_data shows the old value and must not be consumed.
- rd_req and start together in IDLE:
  - no stall;
  - rd_data returns the pre-operation HI/LO, because the MFHI/MFLO is older in program order;
  - the multiply starts normally.
- Back-to-back operations: the second start is accepted in the IDLE cycle following COMMIT. A MADDU accumulates onto the committed result of the previous operation.
- src_a and src_b may change after the start edge without affecting the operation in flight.

Decomposition:
- Shared package mips_pkg holds:
  - funct constants MULTU = 6'd25, MADDU = 6'd1, MFHI = 6'd16, MFLO = 6'd18;
  - op encodings;
  - the IDLE/RUN/COMMIT state encoding.
- One natural sub-module: mips_mul_step, a combinational BITS_PER_CYCLE-bit partial-product/adder slice instantiated by the RUN datapath.
- The FSM, counter and HI/LO registers stay in the top module.

Test Plan:
1. MULTU, a = 3, b = 5, from reset → busy for 33 cycles, done pulses once, hi = 0, lo = 15. A following MFLO gives rd_data = 15.
2. MULTU, a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
3. Build {hi,lo} = 0xFFFFFFFF_FFFFFFFF via MULTU, a = 0xFFFFFFFF, b = 1, then a second MULTU? No: load via MADDU chain, i.e. MULTU 0xFFFFFFFF*1 then MADDU 0xFFFFFFFF*0x00000001 repeated until wrap. Check that MADDU 1*1 on {0xFFFFFFFF,0xFFFFFFFF} yields hi = 0, lo = 0.
4. MFHI asserted 2 cycles after start → stall = 1 until COMMIT completes. rd_data equals the new hi on the first IDLE cycle, and stall falls in the same cycle.
5. start plus rd_req (rd_sel = 0) in IDLE with lo = 7 → stall = 0, rd_data = 7, and the multiply proceeds.
6. rst pulled low 10 cycles into a MULTU → at the next edge busy = 0, hi = lo = 0, no done pulse. With BITS_PER_CYCLE = 4, 3*5 completes in 9 cycles.
